// File: rtl/preddr_ddr_write_scheduler.sv
// Moves 64-bit capture words from the pre-DDR FIFO into fixed-length DDR write bursts.
// It pads the final partial burst, drops words past the capture capacity and pulses done.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | not armed, all outputs quiet
// WAIT_DATA | armed, deciding between next burst, capacity drain or finish
// CMD       | presenting the write command for the next burst
// DATA      | streaming buffered FIFO words as burst beats
// PAD       | capture ended mid-burst, filling the burst with zero beats
// DRAIN     | capacity reached, reading and discarding remaining FIFO words
// DONE      | one-cycle completion pulse
module preddr_ddr_write_scheduler #(
    parameter int ADDR_W    = 30,
    parameter int BURST_LEN = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              I_arm,
    input  logic [ADDR_W-1:0] I_start_addr,
    input  logic [ADDR_W-1:0] I_max_words,
    input  logic              I_capture_done,
    output logic              fifo_rd,
    input  logic [63:0]       fifo_dout,
    input  logic              fifo_empty,
    output logic              ddr_cmd_valid,
    input  logic              ddr_cmd_ready,
    output logic [ADDR_W-1:0] ddr_cmd_addr,
    output logic              ddr_wvalid,
    input  logic              ddr_wready,
    output logic [63:0]       ddr_wdata,
    output logic              ddr_wlast,
    output logic [ADDR_W-1:0] O_words_written,
    output logic              O_busy,
    output logic              O_done,
    output logic              O_overrun
);

    localparam int BEAT_W = $clog2(BURST_LEN);
    localparam logic [ADDR_W-1:0] BURST_A   = ADDR_W'(BURST_LEN);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_DATA, S_CMD, S_DATA, S_PAD, S_DRAIN, S_DONE
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] start_addr;
    logic [ADDR_W-1:0] max_words;
    logic [ADDR_W-1:0] offset;
    logic [BEAT_W-1:0] beat;
    logic              done_seen;
    logic              rd_inflight;
    logic [1:0]        occ;
    logic [63:0]       buf_q [2];

    logic              arm_ok, buf_nonempty, push, pop, beat_fire, last_fire;
    logic              drained_now, drained_after, fits_now, fits_after;
    logic [1:0]        occ_next;
    logic [ADDR_W-1:0] offset_inc;

    assign arm_ok       = I_arm & ((state == S_IDLE) | (state == S_DONE));
    assign buf_nonempty = (occ != 2'd0);

    // Reads in flight count against the 2-entry buffer so it can never overflow.
    assign fifo_rd = ~fifo_empty & ((occ + {1'b0, rd_inflight}) < 2'd2) &
                     ((state == S_WAIT_DATA) | (state == S_CMD) |
                      (state == S_DATA) | (state == S_DRAIN));

    assign ddr_cmd_valid   = (state == S_CMD);
    assign ddr_cmd_addr    = ddr_cmd_valid ? (start_addr + offset) : '0;
    assign ddr_wvalid      = ((state == S_DATA) & buf_nonempty) | (state == S_PAD);
    assign ddr_wdata       = ((state == S_DATA) & buf_nonempty) ? buf_q[0] : 64'd0;
    assign ddr_wlast       = ddr_wvalid & (beat == LAST_BEAT);
    assign O_busy          = (state != S_IDLE);
    assign O_done          = (state == S_DONE);

    assign push      = rd_inflight;
    assign pop       = buf_nonempty & (((state == S_DATA) & ddr_wready) | (state == S_DRAIN));
    assign occ_next  = occ + {1'b0, push} - {1'b0, pop};
    assign beat_fire = ddr_wvalid & ddr_wready;
    assign last_fire = beat_fire & (beat == LAST_BEAT);

    assign offset_inc    = offset + BURST_A;
    assign fits_now      = ({1'b0, offset} + {1'b0, BURST_A}) <= {1'b0, max_words};
    assign fits_after    = ({1'b0, offset_inc} + {1'b0, BURST_A}) <= {1'b0, max_words};
    assign drained_now   = done_seen & fifo_empty & ~buf_nonempty & ~rd_inflight;
    // With the FIFO empty no new read can launch, so an empty buffer after this edge is final.
    assign drained_after = done_seen & fifo_empty & (occ_next == 2'd0);

    function automatic state_t eval_next(input logic nonempty, input logic fits,
                                         input logic drained);
        if (nonempty)
            return fits ? S_CMD : S_DRAIN;
        else if (drained)
            return S_DONE;
        else
            return S_WAIT_DATA;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= S_IDLE;
            start_addr      <= '0;
            max_words       <= '0;
            offset          <= '0;
            beat            <= '0;
            done_seen       <= 1'b0;
            rd_inflight     <= 1'b0;
            occ             <= 2'd0;
            buf_q[0]        <= 64'd0;
            buf_q[1]        <= 64'd0;
            O_words_written <= '0;
            O_overrun       <= 1'b0;
        end else begin
            rd_inflight <= arm_ok ? 1'b0 : fifo_rd;

            if (arm_ok) begin
                occ <= 2'd0;
            end else begin
                occ <= occ_next;
                case ({push, pop})
                    2'b10:   buf_q[occ[0]] <= fifo_dout;
                    2'b01:   buf_q[0] <= buf_q[1];
                    2'b11:   buf_q[0] <= fifo_dout;
                    default: ;
                endcase
            end

            if (arm_ok)
                done_seen <= 1'b0;
            else if (I_capture_done & (state != S_IDLE))
                done_seen <= 1'b1;

            if (arm_ok) begin
                start_addr      <= I_start_addr;
                max_words       <= I_max_words;
                offset          <= '0;
                O_words_written <= '0;
                O_overrun       <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    if (arm_ok) state <= S_WAIT_DATA;
                end
                S_WAIT_DATA: begin
                    state <= eval_next(buf_nonempty, fits_now, drained_now);
                end
                S_CMD: begin
                    if (ddr_cmd_ready) begin
                        state <= S_DATA;
                        beat  <= '0;
                    end
                end
                S_DATA: begin
                    if (beat_fire) begin
                        beat            <= beat + 1'b1;
                        O_words_written <= O_words_written + 1'b1;
                        if (last_fire) begin
                            offset <= offset_inc;
                            state  <= eval_next(occ_next != 2'd0, fits_after, drained_after);
                        end
                    end else if (~buf_nonempty & drained_now) begin
                        state <= S_PAD;
                    end
                end
                S_PAD: begin
                    if (beat_fire) begin
                        beat <= beat + 1'b1;
                        if (last_fire) begin
                            offset <= offset_inc;
                            state  <= eval_next(occ_next != 2'd0, fits_after, drained_after);
                        end
                    end
                end
                S_DRAIN: begin
                    if (buf_nonempty) O_overrun <= 1'b1;
                    if (drained_now) state <= S_DONE;
                end
                S_DONE: begin
                    state <= arm_ok ? S_WAIT_DATA : S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_preddr_ddr_write_scheduler.sv
// Directed bench for preddr_ddr_write_scheduler: FIFO and DDR port models with
// hand-computed burst addresses, beat data, padding, capacity and timing expectations.
module tb_preddr_ddr_write_scheduler;

    localparam int ADDR_W = 30;
    localparam int BL     = 8;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              I_arm = 1'b0;
    logic [ADDR_W-1:0] I_start_addr = '0;
    logic [ADDR_W-1:0] I_max_words = '0;
    logic              I_capture_done = 1'b0;
    logic              fifo_rd;
    logic [63:0]       fifo_dout = 64'd0;
    logic              fifo_empty = 1'b1;
    logic              ddr_cmd_valid;
    logic              ddr_cmd_ready = 1'b1;
    logic [ADDR_W-1:0] ddr_cmd_addr;
    logic              ddr_wvalid;
    logic              ddr_wready = 1'b1;
    logic [63:0]       ddr_wdata;
    logic              ddr_wlast;
    logic [ADDR_W-1:0] O_words_written;
    logic              O_busy, O_done, O_overrun;

    preddr_ddr_write_scheduler #(.ADDR_W(ADDR_W), .BURST_LEN(BL)) dut (
        .clk(clk), .reset(reset), .I_arm(I_arm), .I_start_addr(I_start_addr),
        .I_max_words(I_max_words), .I_capture_done(I_capture_done),
        .fifo_rd(fifo_rd), .fifo_dout(fifo_dout), .fifo_empty(fifo_empty),
        .ddr_cmd_valid(ddr_cmd_valid), .ddr_cmd_ready(ddr_cmd_ready),
        .ddr_cmd_addr(ddr_cmd_addr), .ddr_wvalid(ddr_wvalid), .ddr_wready(ddr_wready),
        .ddr_wdata(ddr_wdata), .ddr_wlast(ddr_wlast), .O_words_written(O_words_written),
        .O_busy(O_busy), .O_done(O_done), .O_overrun(O_overrun)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Non-FWFT FIFO model: read seen in cycle n, data presented from the edge ending it.
    logic [63:0] fq[$];
    logic        rd_seen = 1'b0;
    int          rd_count = 0;
    int          cyc = 0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        rd_seen = fifo_rd;
        if (fifo_rd) chk("rd_when_empty", 64'(fifo_empty), 64'd0);
    end

    always @(posedge clk) begin
        #1;
        if (rd_seen && fq.size() > 0) begin
            fifo_dout = fq.pop_front();
            rd_count++;
        end
        fifo_empty = (fq.size() == 0);
    end

    // DDR ready model: 0 always ready, 1 random wready + cmd_ready after 5 cycles, 2 wready held low.
    int mode = 0;
    int cmd_wait = 0;

    always @(posedge clk) begin
        #2;
        if (ddr_cmd_valid) cmd_wait++;
        else cmd_wait = 0;
        case (mode)
            1: begin
                ddr_wready    = 1'($urandom_range(0, 1));
                ddr_cmd_ready = (cmd_wait >= 5);
            end
            2: begin
                ddr_wready    = 1'b0;
                ddr_cmd_ready = 1'b1;
            end
            default: begin
                ddr_wready    = 1'b1;
                ddr_cmd_ready = 1'b1;
            end
        endcase
    end

    logic [ADDR_W-1:0] cmd_q[$];
    logic [64:0]       beat_q[$];
    int                done_cnt = 0;
    int                done_cyc = 0;
    logic              p_cv = 1'b0, p_cr = 1'b0, p_wv = 1'b0, p_wr = 1'b0, p_wl = 1'b0;
    logic [ADDR_W-1:0] p_ca = '0;
    logic [63:0]       p_wd = 64'd0;

    always @(negedge clk) begin
        if (!reset && p_cv && !p_cr) begin
            chk("cmd_hold_valid", 64'(ddr_cmd_valid), 64'd1);
            chk("cmd_hold_addr", 64'(ddr_cmd_addr), 64'(p_ca));
        end
        if (!reset && p_wv && !p_wr) begin
            chk("w_hold_valid", 64'(ddr_wvalid), 64'd1);
            chk("w_hold_data", ddr_wdata, p_wd);
            chk("w_hold_last", 64'(ddr_wlast), 64'(p_wl));
        end
        if (ddr_cmd_valid && ddr_cmd_ready) cmd_q.push_back(ddr_cmd_addr);
        if (ddr_wvalid && ddr_wready) beat_q.push_back({ddr_wlast, ddr_wdata});
        if (O_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        p_cv = ddr_cmd_valid; p_cr = ddr_cmd_ready; p_ca = ddr_cmd_addr;
        p_wv = ddr_wvalid;    p_wr = ddr_wready;    p_wd = ddr_wdata; p_wl = ddr_wlast;
    end

    task automatic clear_logs();
        cmd_q.delete();
        beat_q.delete();
        done_cnt = 0;
        rd_count = 0;
    endtask

    task automatic arm(input logic [ADDR_W-1:0] start, input logic [ADDR_W-1:0] maxw);
        @(posedge clk); #2;
        I_start_addr = start;
        I_max_words  = maxw;
        I_arm        = 1'b1;
        @(posedge clk); #2;
        I_arm        = 1'b0;
    endtask

    task automatic push_words(input int n, input logic [63:0] base);
        @(posedge clk); #2;
        for (int i = 0; i < n; i++) fq.push_back(base + 64'(i));
        if (n > 0) fifo_empty = 1'b0;
    endtask

    task automatic cap_done();
        @(posedge clk); #2;
        I_capture_done = 1'b1;
        @(posedge clk); #2;
        I_capture_done = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (done_cnt == 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk({tag, "_done_pulses"}, 64'(done_cnt), 64'd1);
        chk({tag, "_busy_after"}, 64'(O_busy), 64'd0);
    endtask

    task automatic verify(input string tag, input int n_cmds, input logic [ADDR_W-1:0] a0,
                          input int n_real, input int n_total, input logic [63:0] base);
        chk({tag, "_ncmd"}, 64'(cmd_q.size()), 64'(n_cmds));
        for (int i = 0; i < n_cmds && i < cmd_q.size(); i++)
            chk({tag, "_addr"}, 64'(cmd_q[i]), 64'(a0 + ADDR_W'(i * BL)));
        chk({tag, "_nbeats"}, 64'(beat_q.size()), 64'(n_total));
        for (int i = 0; i < n_total && i < beat_q.size(); i++) begin
            chk({tag, "_data"}, beat_q[i][63:0], (i < n_real) ? base + 64'(i) : 64'd0);
            chk({tag, "_last"}, 64'(beat_q[i][64]), 64'((i % BL) == BL - 1));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int n;
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        chk("rst_busy", 64'(O_busy), 64'd0);
        chk("rst_done", 64'(O_done), 64'd0);
        chk("rst_cmd_valid", 64'(ddr_cmd_valid), 64'd0);
        chk("rst_wvalid", 64'(ddr_wvalid), 64'd0);
        chk("rst_fifo_rd", 64'(fifo_rd), 64'd0);
        chk("rst_words", 64'(O_words_written), 64'd0);
        chk("rst_overrun", 64'(O_overrun), 64'd0);

        // two full bursts
        clear_logs();
        arm(30'h100, 30'd64);
        push_words(16, 64'h1111_0000_0000_0000);
        cap_done();
        wait_done("full", 400);
        verify("full", 2, 30'h100, 16, 16, 64'h1111_0000_0000_0000);
        chk("full_words", 64'(O_words_written), 64'd16);
        chk("full_overrun", 64'(O_overrun), 64'd0);

        // partial last burst padded with zeros
        clear_logs();
        arm(30'h40, 30'd64);
        push_words(11, 64'h2222_0000_0000_0000);
        cap_done();
        wait_done("pad", 400);
        verify("pad", 2, 30'h40, 11, 16, 64'h2222_0000_0000_0000);
        chk("pad_words", 64'(O_words_written), 64'd11);

        // backpressure on both channels
        clear_logs();
        mode = 1;
        arm(30'h0, 30'd1024);
        push_words(64, 64'h3333_0000_0000_0000);
        cap_done();
        wait_done("stall", 3000);
        mode = 0;
        verify("stall", 8, 30'h0, 64, 64, 64'h3333_0000_0000_0000);
        chk("stall_words", 64'(O_words_written), 64'd64);

        // capacity limit, excess words discarded
        clear_logs();
        arm(30'h300, 30'd16);
        push_words(40, 64'h4444_0000_0000_0000);
        cap_done();
        wait_done("cap", 600);
        verify("cap", 2, 30'h300, 16, 16, 64'h4444_0000_0000_0000);
        chk("cap_words", 64'(O_words_written), 64'd16);
        chk("cap_overrun", 64'(O_overrun), 64'd1);
        chk("cap_reads", 64'(rd_count), 64'd40);
        chk("cap_fifo_left", 64'(fq.size()), 64'd0);

        // completion with no data
        clear_logs();
        arm(30'h700, 30'd64);
        @(posedge clk); #2;
        k = cyc;
        I_capture_done = 1'b1;
        @(posedge clk); #2;
        I_capture_done = 1'b0;
        wait_done("nodata", 20);
        chk("nodata_latency", 64'(done_cyc - k), 64'd2);
        chk("nodata_ncmd", 64'(cmd_q.size()), 64'd0);
        chk("nodata_words", 64'(O_words_written), 64'd0);

        // arm ignored mid-DATA, then reset mid-DATA
        clear_logs();
        mode = 2;
        arm(30'h500, 30'd64);
        push_words(12, 64'h6666_0000_0000_0000);
        n = 0;
        while (!ddr_wvalid && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("mid_wvalid_seen", 64'(ddr_wvalid), 64'd1);
        arm(30'h900, 30'd8);
        @(negedge clk);
        chk("mid_arm_wvalid", 64'(ddr_wvalid), 64'd1);
        chk("mid_arm_busy", 64'(O_busy), 64'd1);
        mode = 0;
        n = 0;
        while (O_words_written != 30'd12 && n < 100) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        verify("mid", 2, 30'h500, 12, 12, 64'h6666_0000_0000_0000);
        chk("mid_words", 64'(O_words_written), 64'd12);
        chk("mid_busy_pre", 64'(O_busy), 64'd1);
        @(posedge clk); #2;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("mid_rst_busy", 64'(O_busy), 64'd0);
        chk("mid_rst_words", 64'(O_words_written), 64'd0);
        chk("mid_rst_cmd", 64'(ddr_cmd_valid), 64'd0);
        chk("mid_rst_wvalid", 64'(ddr_wvalid), 64'd0);
        chk("mid_rst_wdata", ddr_wdata, 64'd0);
        chk("mid_rst_fifo_rd", 64'(fifo_rd), 64'd0);
        chk("mid_rst_done", 64'(O_done), 64'd0);
        @(posedge clk); #2;
        reset = 1'b0;
        repeat (2) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/preddr_ddr_write_scheduler.md
Name: preddr_ddr_write_scheduler

Overview:
Sequences the transfer of assembled 64-bit capture words from the pre-DDR FIFO into the DDR write port. It pulls words from the FIFO read side, groups them into fixed-length bursts, issues one write command per burst at an incrementing word address, pads the final partial burst, enforces a capture-capacity limit and signals completion. Sits in the FIFO read-clock domain, between the 18-to-64 converter's FIFO read port and the DDR controller's user write interface.

Parameters:
ADDR_W, 30, width of DDR word address, capacity and word counters (units of 64-bit words)
BURST_LEN, 8, data beats per write command; power of two, 2..64

Ports:
clk  in  1  scheduler clock (converter rd_clk)
reset  in  1  synchronous active-high reset
I_arm  in  1  one-cycle pulse: start a new capture transfer
I_start_addr  in  ADDR_W  first DDR word address; sampled on accepted I_arm
I_max_words  in  ADDR_W  capacity in words; sampled on accepted I_arm
I_capture_done  in  1  one-cycle pulse from converter (capture_done_out)
fifo_rd  out  1  FIFO read strobe
fifo_dout  in  64  FIFO data; valid the cycle after fifo_rd (non-FWFT)
fifo_empty  in  1  FIFO empty
ddr_cmd_valid  out  1  write command valid
ddr_cmd_ready  in  1  command accepted when valid & ready
ddr_cmd_addr  out  ADDR_W  burst start word address
ddr_wvalid  out  1  write data valid
ddr_wready  in  1  beat accepted when wvalid & wready
ddr_wdata  out  64  write data
ddr_wlast  out  1  last beat of burst
O_words_written  out  ADDR_W  real (non-pad) beats accepted since arm
O_busy  out  1  high in every state except IDLE
O_done  out  1  one-cycle completion pulse
O_overrun  out  1  sticky: FIFO words discarded due to capacity

Behaviour:
- Reset: every output 0, state IDLE, counters/buffer/flags cleared; takes effect on the next edge regardless of state, including mid-burst.
- I_arm accepted only in IDLE or DONE; ignored otherwise. On accept: offset=0, O_words_written=0, O_overrun=0, done_seen=0, buffer flushed, state WAIT_DATA.
- done_seen: set by I_capture_done in any non-IDLE state; cleared on accepted I_arm.
- Holding buffer: 2 entries. fifo_rd = ~fifo_empty & (occupancy + reads in flight < 2) & state in {WAIT_DATA, CMD, DATA, DRAIN}. Data written to buffer the cycle after fifo_rd. Never assert fifo_rd while fifo_empty.
- drained = done_seen & fifo_empty & buffer empty & no read in flight.
- WAIT_DATA: buffer non-empty & offset+BURST_LEN <= max → CMD. Buffer non-empty & offset+BURST_LEN > max → DRAIN. Else drained → DONE.
- CMD: ddr_cmd_valid=1, ddr_cmd_addr=start_addr+offset, both held stable until ready; on handshake → DATA, beat=0.
- DATA: ddr_wvalid = buffer non-empty; ddr_wdata = buffer head; ddr_wlast = (beat==BURST_LEN-1). Each accepted beat pops the buffer and increments beat and O_words_written. If buffer empty and drained → PAD.
- PAD: ddr_wvalid=1, ddr_wdata=0, same wlast rule; O_words_written not incremented.
- Last beat accepted (DATA or PAD): offset += BURST_LEN, then apply the WAIT_DATA rules in the same cycle (next state WAIT_DATA, DRAIN or DONE).
- DRAIN: fifo_rd per the buffer rule; buffer popped every cycle, nothing sent to DDR; O_overrun=1 on the first discarded word. drained → DONE.
- DONE: O_done=1 for exactly one cycle, then → IDLE unless I_arm is accepted in that cycle.
- Address arithmetic is modulo 2^ADDR_W; no wrap check beyond capacity.
- I_capture_done concurrent with the last beat: done_seen is still set, and the transition out uses the updated value on the next evaluation.

Test Plan:
- Arm start=0x100, max=64; push 16 words, then I_capture_done -> cmds at 0x100 and 0x108, 16 beats in order, wlast on beats 8 and 16, no pad, O_words_written=16, one O_done pulse.
- Push 11 words then done -> second burst carries 3 real words + 5 zero beats, wlast on the 16th beat, O_words_written=11.
- Random 50% wready and cmd_ready delayed 5 cycles, 64 words -> data/addr stable while stalled, no loss or duplication, fifo_rd never asserted with fifo_empty=1.
- max=16, push 40 words -> exactly 2 bursts, 24 words read and discarded, O_overrun=1, O_done after FIFO drains.
- Done with no data -> no ddr_cmd_valid, O_done within 2 cycles, O_words_written=0.
- I_arm mid-DATA -> ignored; reset asserted mid-DATA -> next cycle all outputs 0, state IDLE, O_busy=0.
